// File: rtl/ckt_pkg.sv
// Shared definitions for the checkpoint timer: state encoding, firmware-visible
// default checkpoint codes and the default prescale.
package ckt_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_TOUT  = 3'd4;

  localparam int          DEF_CHK_W      = 16;
  localparam int          DEF_CNT_W      = 32;
  localparam int          DEF_PRESCALE   = 1000;
  localparam int          DEF_TIMEOUT_K  = 150;
  localparam logic [15:0] DEF_START_CODE = 16'hA000;
  localparam logic [15:0] DEF_STOP_CODE  = 16'hAB00;

  // States in which the arm (timeout) counter advances.
  function automatic logic is_measuring(input logic [2:0] st);
    return (st == ST_ARMED) || (st == ST_RUN);
  endfunction

  // Terminal states that raise irq on entry.
  function automatic logic is_final(input logic [2:0] st);
    return (st == ST_DONE) || (st == ST_TOUT);
  endfunction

endpackage

// File: rtl/ckt_prescaler.sv
// Enable-gated modulo-MOD counter; tick marks the clock on which the count
// wraps and one whole unit has elapsed. clr wins over en.
module ckt_prescaler
  import ckt_pkg::*;
#(
  parameter int MOD = DEF_PRESCALE,
  parameter int CW  = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick  = en && !clr && (count_q == LAST);
  assign count = count_q;

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/checkpoint_timer.sv
// Cycle-measurement controller: watches the firmware checkpoint word, counts
// PRESCALE-clock units between start and stop codes, and aborts on timeout.
module checkpoint_timer
  import ckt_pkg::*;
#(
  parameter int               CHK_W      = DEF_CHK_W,
  parameter int               CNT_W      = DEF_CNT_W,
  parameter int               PRESCALE   = DEF_PRESCALE,
  parameter logic [CHK_W-1:0] START_CODE = CHK_W'(DEF_START_CODE),
  parameter logic [CHK_W-1:0] STOP_CODE  = CHK_W'(DEF_STOP_CODE),
  parameter int               TIMEOUT_K  = DEF_TIMEOUT_K
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [CHK_W-1:0]            checkbits,
  output logic [CNT_W-1:0]            kcycles,
  output logic [$clog2(PRESCALE)-1:0] frac,
  output logic [2:0]                  state,
  output logic                        done,
  output logic                        timeout,
  output logic                        irq
);

  localparam int               FW       = $clog2(PRESCALE);
  localparam int               AW       = (TIMEOUT_K > 0) ? $clog2(TIMEOUT_K + 1) : 1;
  localparam logic [FW-1:0]    PRE_LAST = FW'(PRESCALE - 1);
  localparam logic [AW-1:0]    K_LAST   = AW'((TIMEOUT_K > 0) ? TIMEOUT_K - 1 : 0);

  logic [CHK_W-1:0] sync1_q, sync1_d;
  logic [CHK_W-1:0] sync2_q, sync2_d;
  logic [CHK_W-1:0] prev_q, prev_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] kcyc_q, kcyc_d;
  logic [AW-1:0]    arm_units_q, arm_units_d;
  logic             irq_q, irq_d;

  logic             start_evt, stop_evt, tout_hit, clear_hit;
  logic             meas_en, meas_clr, meas_tick;
  logic             arm_en, arm_clr, arm_tick;
  logic [FW-1:0]    meas_frac, arm_frac;

  // Edge semantics: a code fires only on the cycle it first appears.
  assign start_evt = (sync2_q != prev_q) && (sync2_q == START_CODE);
  assign stop_evt  = (sync2_q != prev_q) && (sync2_q == STOP_CODE);

  assign clear_hit = enable && clear && (state_q != ST_IDLE);
  assign arm_en    = is_measuring(state_q);
  assign tout_hit  = (TIMEOUT_K != 0) && arm_en &&
                     (arm_units_q == K_LAST) && (arm_frac == PRE_LAST);

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: begin
          if (clear)          state_d = ST_ARMED;
          else if (tout_hit)  state_d = ST_TOUT;
          else if (start_evt) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (clear)         state_d = ST_ARMED;
          else if (tout_hit) state_d = ST_TOUT;
          else if (stop_evt) state_d = ST_DONE;
        end
        ST_DONE, ST_TOUT: begin
          if (clear) state_d = ST_ARMED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The measurement only advances on cycles that stay in RUN, so stop and
  // timeout edges freeze it at its pre-edge value; a restart zeroes it.
  assign meas_en  = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign meas_clr = (state_d == ST_IDLE) || (state_d == ST_ARMED) ||
                    (start_evt && (state_q == ST_RUN) && (state_d == ST_RUN));
  assign arm_clr  = (state_d == ST_IDLE) || clear_hit;

  ckt_prescaler #(.MOD(PRESCALE)) u_meas_pre (
    .clk    (clk),
    .resetn (resetn),
    .en     (meas_en),
    .clr    (meas_clr),
    .count  (meas_frac),
    .tick   (meas_tick)
  );

  ckt_prescaler #(.MOD(PRESCALE)) u_arm_pre (
    .clk    (clk),
    .resetn (resetn),
    .en     (arm_en),
    .clr    (arm_clr),
    .count  (arm_frac),
    .tick   (arm_tick)
  );

  always_comb begin
    sync1_d = checkbits;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    kcyc_d = kcyc_q;
    if (meas_clr) begin
      kcyc_d = '0;
    end else if (meas_tick && (kcyc_q != '1)) begin
      kcyc_d = kcyc_q + CNT_W'(1);
    end

    arm_units_d = arm_units_q;
    if (arm_clr) begin
      arm_units_d = '0;
    end else if (arm_tick) begin
      arm_units_d = arm_units_q + AW'(1);
    end

    irq_d = is_final(state_d) && (state_d != state_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      state_q     <= ST_IDLE;
      kcyc_q      <= '0;
      arm_units_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      kcyc_q      <= kcyc_d;
      arm_units_q <= arm_units_d;
      irq_q       <= irq_d;
    end
  end

  assign kcycles = kcyc_q;
  assign frac    = meas_frac;
  assign state   = state_q;
  assign done    = (state_q == ST_DONE);
  assign timeout = (state_q == ST_TOUT);
  assign irq     = irq_q;

endmodule
